mem_arbiter: RTL and testbench

Two-master arbiter that shares the single-port `mem` block between the multicycle RISC-V core and a second bus master (program loader / DMA). It sits between the requesters and `mem`. Grants are registered. Selection is round-robin, with optional lock for back-to-back bursts and a hold limit that bounds starvation. Accesses complete in the cycle where a master has both request and grant: write on that clock edge, read data combinational in that cycle.

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Purpose: bundles both master request ports and the shared mem port of mem_arbiter.
// Latency: wires only. The arbiter defines all timing.
// Backpressure: a master stalls on its own gnt_k. The mem side has no flow control.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req_0;
    logic          we_0;
    logic [AW-1:0] addr_0;
    logic [DW-1:0] wdata_0;
    logic          lock_0;
    logic          gnt_0;
    logic [DW-1:0] rdata_0;

    logic          req_1;
    logic          we_1;
    logic [AW-1:0] addr_1;
    logic [DW-1:0] wdata_1;
    logic          lock_1;
    logic          gnt_1;
    logic [DW-1:0] rdata_1;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter view: it takes requests and read data, and drives grants and the mem port.
    modport slave (
        input  req_0, we_0, addr_0, wdata_0, lock_0,
        input  req_1, we_1, addr_1, wdata_1, lock_1,
        input  mem_rdata,
        output gnt_0, rdata_0, gnt_1, rdata_1,
        output mem_we, mem_addr, mem_wdata
    );

    // Requester/memory view: the mirror image of the slave view.
    modport master (
        output req_0, we_0, addr_0, wdata_0, lock_0,
        output req_1, we_1, addr_1, wdata_1, lock_1,
        output mem_rdata,
        input  gnt_0, rdata_0, gnt_1, rdata_1,
        input  mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter with lock and hold limit in front of a single-port mem.
// Latency: the grant is registered, one cycle after the request from IDLE. A handover has no bubble.
// Backpressure: a master waits for gnt_k. The wait is bounded by MAX_HOLD+1 cycles.
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          prio;
    logic [HW-1:0] hold_cnt;
    logic          gnt_0_q;
    logic          gnt_1_q;

    logic          mux_we;
    logic [AW-1:0] mux_addr;
    logic [DW-1:0] mux_wdata;

    // Next owner: a stalled owner yields at once. A lock keeps the grant only below the hold limit.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req_0 && bus.req_1) state_nxt = prio ? OWN1 : OWN0;
                else if (bus.req_0)         state_nxt = OWN0;
                else if (bus.req_1)         state_nxt = OWN1;
                else                        state_nxt = IDLE;
            end
            OWN0: begin
                if (!bus.req_0)                                state_nxt = bus.req_1 ? OWN1 : IDLE;
                else if (!bus.req_1)                           state_nxt = OWN0;
                else if (bus.lock_0 && (hold_cnt < HOLD_MAX))  state_nxt = OWN0;
                else                                           state_nxt = OWN1;
            end
            OWN1: begin
                if (!bus.req_1)                                state_nxt = bus.req_0 ? OWN0 : IDLE;
                else if (!bus.req_0)                           state_nxt = OWN1;
                else if (bus.lock_1 && (hold_cnt < HOLD_MAX))  state_nxt = OWN1;
                else                                           state_nxt = OWN0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Update the owner, the registered grants, the tie-break pointer and the hold counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            prio     <= 1'b0;
            hold_cnt <= '0;
            gnt_0_q  <= 1'b0;
            gnt_1_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            gnt_0_q <= (state_nxt == OWN0);
            gnt_1_q <= (state_nxt == OWN1);
            if (state_nxt == IDLE) begin
                hold_cnt <= '0;
            end else if (state_nxt != state) begin
                // A new owner starts its hold count and gives the next tie to the other master.
                hold_cnt <= HW'(1);
                prio     <= (state_nxt == OWN0);
            end else if (hold_cnt < HOLD_MAX) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    // Steer the owner's request onto mem. Reset blocks the write so an access in flight is dropped.
    always_comb begin
        mux_we    = 1'b0;
        mux_addr  = '0;
        mux_wdata = '0;
        case (state)
            OWN0: begin
                mux_we    = bus.req_0 & bus.we_0;
                mux_addr  = bus.addr_0;
                mux_wdata = bus.wdata_0;
            end
            OWN1: begin
                mux_we    = bus.req_1 & bus.we_1;
                mux_addr  = bus.addr_1;
                mux_wdata = bus.wdata_1;
            end
            default: begin
                mux_we    = 1'b0;
                mux_addr  = '0;
                mux_wdata = '0;
            end
        endcase
        if (reset) mux_we = 1'b0;
    end

    assign bus.mem_we    = mux_we;
    assign bus.mem_addr  = mux_addr;
    assign bus.mem_wdata = mux_wdata;

    assign bus.gnt_0   = gnt_0_q;
    assign bus.gnt_1   = gnt_1_q;
    assign bus.rdata_0 = gnt_0_q ? bus.mem_rdata : '0;
    assign bus.rdata_1 = gnt_1_q ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed vectors and corner sequences for mem_arbiter, with a small behavioural mem behind it.
// Latency: inputs change on the falling edge. Outputs are sampled 1 ns later.
// Backpressure: none. The stimulus is fixed and every loop is bounded.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(.AW(32), .DW(32), .MAX_HOLD(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] tb_mem [0:63];

    assign bus.mem_rdata = tb_mem[bus.mem_addr[7:2]];

    // Behavioural single-port memory: write on the rising edge, read combinationally.
    always @(posedge clk) begin
        if (bus.mem_we) tb_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, r0, r1, l0, w0, w1;
        logic [31:0] a0, a1, d0, d1;
        logic        g0, g1, mwe;
        logic [31:0] maddr, rd1;
    } vec_t;

    function automatic vec_t mk(input logic rst, r0, r1, l0, w0, w1,
                                input logic [31:0] a0, a1, d0, d1,
                                input logic g0, g1, mwe,
                                input logic [31:0] maddr, rd1);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.l0 = l0; v.w0 = w0; v.w1 = w1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.mwe = mwe; v.maddr = maddr; v.rd1 = rd1;
        return v;
    endfunction

    vec_t vt [0:20];

    initial begin
        int g0_run;
        int first_g1;
        int overlap;

        for (int i = 0; i < 64; i++) tb_mem[i] = 32'h0;

        //            rst r0 r1 l0 w0 w1  a0       a1       d0 d1             g0 g1 mwe maddr    rd1
        vt[0]  = mk(1, 1, 1, 0, 0, 0, 32'h100, 32'h200, 0, 0,            0, 0, 0, 32'h0,   32'h0);
        vt[1]  = mk(1, 1, 1, 0, 0, 0, 32'h100, 32'h200, 0, 0,            0, 0, 0, 32'h0,   32'h0);
        vt[2]  = mk(0, 1, 1, 0, 0, 0, 32'h100, 32'h200, 0, 0,            0, 0, 0, 32'h0,   32'h0);
        vt[3]  = mk(0, 0, 0, 0, 0, 0, 32'h100, 32'h200, 0, 0,            1, 0, 0, 32'h100, 32'h0);
        vt[4]  = mk(0, 0, 1, 0, 0, 1, 32'h0,   32'h40,  0, 32'hDEADBEEF, 0, 0, 0, 32'h0,   32'h0);
        vt[5]  = mk(0, 0, 1, 0, 0, 1, 32'h0,   32'h40,  0, 32'hDEADBEEF, 0, 1, 1, 32'h40,  32'h0);
        vt[6]  = mk(0, 0, 1, 0, 0, 0, 32'h0,   32'h40,  0, 0,            0, 1, 0, 32'h40,  32'hDEADBEEF);
        vt[7]  = mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h40,  0, 0,            0, 1, 0, 32'h40,  32'hDEADBEEF);
        vt[8]  = mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h40,  0, 0,            0, 0, 0, 32'h0,   32'h0);
        vt[9]  = mk(0, 1, 1, 0, 0, 0, 32'h10,  32'h14,  0, 0,            0, 0, 0, 32'h0,   32'h0);
        vt[10] = mk(0, 1, 1, 0, 0, 0, 32'h10,  32'h14,  0, 0,            1, 0, 0, 32'h10,  32'h0);
        vt[11] = mk(0, 1, 1, 0, 0, 0, 32'h10,  32'h14,  0, 0,            0, 1, 0, 32'h14,  32'h0);
        vt[12] = mk(0, 1, 1, 0, 0, 0, 32'h10,  32'h14,  0, 0,            1, 0, 0, 32'h10,  32'h0);
        vt[13] = mk(0, 1, 1, 0, 0, 0, 32'h10,  32'h14,  0, 0,            0, 1, 0, 32'h14,  32'h0);
        vt[14] = mk(0, 1, 1, 0, 0, 0, 32'h10,  32'h14,  0, 0,            1, 0, 0, 32'h10,  32'h0);
        vt[15] = mk(0, 1, 1, 0, 0, 0, 32'h10,  32'h14,  0, 0,            0, 1, 0, 32'h14,  32'h0);
        vt[16] = mk(0, 1, 1, 1, 0, 1, 32'h10,  32'h20,  0, 32'h55,       1, 0, 0, 32'h10,  32'h0);
        vt[17] = mk(0, 1, 1, 1, 0, 1, 32'h10,  32'h20,  0, 32'h55,       1, 0, 0, 32'h10,  32'h0);
        vt[18] = mk(0, 1, 1, 0, 0, 1, 32'h10,  32'h20,  0, 32'h55,       1, 0, 0, 32'h10,  32'h0);
        vt[19] = mk(0, 0, 1, 0, 0, 1, 32'h10,  32'h20,  0, 32'h55,       0, 1, 1, 32'h20,  32'h0);
        vt[20] = mk(0, 0, 0, 0, 0, 1, 32'h10,  32'h20,  0, 32'h55,       0, 1, 0, 32'h20,  32'h55);

        reset = 1'b1;
        bus.req_0 = 1'b1; bus.we_0 = 1'b0; bus.addr_0 = '0; bus.wdata_0 = '0; bus.lock_0 = 1'b0;
        bus.req_1 = 1'b1; bus.we_1 = 1'b0; bus.addr_1 = '0; bus.wdata_1 = '0; bus.lock_1 = 1'b0;
        @(posedge clk);

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            reset       = vt[i].rst;
            bus.req_0   = vt[i].r0;
            bus.req_1   = vt[i].r1;
            bus.lock_0  = vt[i].l0;
            bus.we_0    = vt[i].w0;
            bus.we_1    = vt[i].w1;
            bus.addr_0  = vt[i].a0;
            bus.addr_1  = vt[i].a1;
            bus.wdata_0 = vt[i].d0;
            bus.wdata_1 = vt[i].d1;
            #1;
            chk($sformatf("v%0d gnt_0", i),    32'(bus.gnt_0),  32'(vt[i].g0));
            chk($sformatf("v%0d gnt_1", i),    32'(bus.gnt_1),  32'(vt[i].g1));
            chk($sformatf("v%0d mem_we", i),   32'(bus.mem_we), 32'(vt[i].mwe));
            chk($sformatf("v%0d mem_addr", i), bus.mem_addr,    vt[i].maddr);
            chk($sformatf("v%0d rdata_1", i),  bus.rdata_1,     vt[i].rd1);
        end
        @(negedge clk);
        chk("mem40 written", tb_mem[16], 32'hDEADBEEF);
        chk("mem20 written", tb_mem[8],  32'h55);

        // Lock starvation bound: master 0 locks, master 1 joins at cycle 3.
        g0_run = 0; first_g1 = -1; overlap = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (cyc > 0) @(negedge clk);
            bus.req_0 = 1'b1; bus.lock_0 = 1'b1; bus.we_0 = 1'b0; bus.addr_0 = 32'h10;
            bus.req_1 = (cyc >= 3); bus.we_1 = 1'b0; bus.addr_1 = 32'h14;
            #1;
            if (bus.gnt_0 && bus.gnt_1) overlap++;
            if (first_g1 < 0 && bus.gnt_1) first_g1 = cyc;
            if (first_g1 < 0 && bus.gnt_0) g0_run++;
        end
        chk("lock gnt_0 run", 32'(g0_run), 32'd8);
        chk("lock gnt_1 cycle", 32'(first_g1), 32'd9);
        chk("grant overlap", 32'(overlap), 32'd0);

        @(negedge clk);
        bus.req_0 = 1'b0; bus.req_1 = 1'b0; bus.lock_0 = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset in the middle of a locked write burst from master 0.
        bus.req_0 = 1'b1; bus.lock_0 = 1'b1; bus.we_0 = 1'b1; bus.addr_0 = 32'h8; bus.wdata_0 = 32'h11;
        #1;
        chk("burst req gnt_0", 32'(bus.gnt_0), 32'd0);
        @(negedge clk);
        #1;
        chk("burst first gnt_0", 32'(bus.gnt_0), 32'd1);
        chk("burst first mem_we", 32'(bus.mem_we), 32'd1);
        @(negedge clk);
        bus.wdata_0 = 32'h22;
        #1;
        chk("burst mem8 first", tb_mem[2], 32'h11);
        @(negedge clk);
        reset = 1'b1; bus.wdata_0 = 32'h33;
        #1;
        chk("reset cycle mem_we", 32'(bus.mem_we), 32'd0);
        chk("reset cycle gnt_0", 32'(bus.gnt_0), 32'd1);
        @(negedge clk);
        reset = 1'b0; bus.req_0 = 1'b0; bus.we_0 = 1'b0; bus.lock_0 = 1'b0;
        #1;
        chk("after reset gnt_0", 32'(bus.gnt_0), 32'd0);
        chk("after reset mem8", tb_mem[2], 32'h22);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
